// File: rtl/matrix_bank_dp.sv
// Banked ROWS x COLS matrix store with (row, col) decode to bank/offset, a valid/ready
// write port and a row-major burst read engine with a fixed two-cycle read latency.
module matrix_bank_dp #(
  parameter int DATA_W = 32,
  parameter int ROWS   = 1024,
  parameter int COLS   = 1024,
  parameter int NBANKS = 16,
  parameter int LEN_W  = 10
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(ROWS)-1:0]  wr_row,
  input  logic [$clog2(COLS)-1:0]  wr_col,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_req_valid,
  output logic                     rd_req_ready,
  input  logic [$clog2(ROWS)-1:0]  rd_row,
  input  logic [$clog2(COLS)-1:0]  rd_col,
  input  logic [LEN_W-1:0]         rd_len,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_last,
  output logic                     busy
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int IW    = RW + CW;
  localparam int BW    = $clog2(NBANKS);
  localparam int OW    = IW - BW;
  localparam int DEPTH = (ROWS * COLS) / NBANKS;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_reg, state_next;
  logic [IW-1:0]      idx_reg, idx_next;
  logic [LEN_W-1:0]   cnt_reg, cnt_next;

  logic               iss_fire;
  logic               iss_last;
  logic [IW-1:0]      iss_idx;
  logic [BW-1:0]      iss_bank;
  logic [OW-1:0]      iss_off;

  logic               wr_fire;
  logic [IW-1:0]      wr_idx;
  logic [BW-1:0]      wr_bank;
  logic [OW-1:0]      wr_off;

  logic               s1_valid_reg;
  logic               s1_last_reg;
  logic [BW-1:0]      s1_bank_reg;
  logic [OW-1:0]      s1_off_reg;
  logic               s1_coll_reg;
  logic [DATA_W-1:0]  s1_snap_reg;

  logic [DATA_W-1:0]  bank_q [NBANKS];
  logic [DATA_W-1:0]  iss_q  [NBANKS];

  // Power-of-two dimensions make row*COLS+col a plain concatenation.
  assign wr_ready = !RST;
  assign wr_fire  = wr_valid && !RST;
  assign wr_idx   = {wr_row, wr_col};
  assign wr_bank  = wr_idx[IW-1 -: BW];
  assign wr_off   = wr_idx[OW-1:0];
  assign iss_bank = iss_idx[IW-1 -: BW];
  assign iss_off  = iss_idx[OW-1:0];

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    iss_fire     = 1'b0;
    iss_last     = 1'b0;
    iss_idx      = idx_reg + IW'(1);
    rd_req_ready = 1'b0;
    if (!RST) begin
      case (state_reg)
        IDLE: begin
          rd_req_ready = 1'b1;
          if (rd_req_valid) begin
            iss_fire = 1'b1;
            iss_idx  = {rd_row, rd_col};
            idx_next = {rd_row, rd_col};
            cnt_next = rd_len;
            iss_last = (rd_len == '0);
            if (rd_len != '0) state_next = BURST;
          end
        end
        BURST: begin
          // Incrementing the concatenated index gives col/row carry and the full wrap.
          iss_fire = 1'b1;
          idx_next = iss_idx;
          cnt_next = cnt_reg - LEN_W'(1);
          iss_last = (cnt_reg == LEN_W'(1));
          if (cnt_reg == LEN_W'(1)) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBANKS; gi++) begin : g_bank
      logic [DATA_W-1:0] mem [DEPTH];

      always_ff @(posedge CLK) begin
        if (wr_fire && (wr_bank == BW'(gi))) mem[wr_off] <= wr_data;
      end

      assign bank_q[gi] = mem[s1_off_reg];
      assign iss_q[gi]  = mem[iss_off];
    end
  endgenerate

  // A write landing on the element issued this cycle would otherwise be seen by the
  // stage-2 read, so the pre-write word is captured at issue time instead.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_bank_reg  <= '0;
      s1_off_reg   <= '0;
      s1_coll_reg  <= 1'b0;
      s1_snap_reg  <= '0;
    end else begin
      s1_valid_reg <= iss_fire;
      s1_last_reg  <= iss_last;
      s1_bank_reg  <= iss_bank;
      s1_off_reg   <= iss_off;
      s1_coll_reg  <= iss_fire && wr_fire && (wr_idx == iss_idx);
      s1_snap_reg  <= iss_q[iss_bank];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= s1_valid_reg;
      rd_last  <= s1_valid_reg && s1_last_reg;
      if (s1_valid_reg) rd_data <= s1_coll_reg ? s1_snap_reg : bank_q[s1_bank_reg];
    end
  end

  assign busy = !RST && ((state_reg == BURST) || s1_valid_reg || rd_valid);

endmodule

// File: tb/tb_matrix_bank_dp.sv
// Bench for matrix_bank_dp: directed and random traffic against a queue-based model
// of element issue order, two-cycle latency and read-before-write memory semantics.
module tb_matrix_bank_dp;

  localparam int DW = 32, NR = 16, NC = 16, NB = 4, LW = 6;
  localparam int NE = NR * NC;

  logic          CLK = 1'b0;
  logic          RST;
  logic          wr_valid, wr_ready;
  logic [3:0]    wr_row, wr_col;
  logic [DW-1:0] wr_data;
  logic          rd_req_valid, rd_req_ready;
  logic [3:0]    rd_row, rd_col;
  logic [LW-1:0] rd_len;
  logic          rd_valid, rd_last, busy;
  logic [DW-1:0] rd_data;

  always #5 CLK = ~CLK;

  matrix_bank_dp #(.DATA_W(DW), .ROWS(NR), .COLS(NC), .NBANKS(NB), .LEN_W(LW)) dut (
    .CLK(CLK), .RST(RST),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_row(rd_row), .rd_col(rd_col), .rd_len(rd_len),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .busy(busy)
  );

  typedef struct { int due; logic [DW-1:0] d; logic last; } beat_t;

  logic [DW-1:0] mem_m [NE];
  int            pend [$];
  beat_t         expq [$];
  logic [DW-1:0] last_data;
  int            cyc, n_pass, n_total;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  // One clock: compare outputs against the model, then advance the model by one cycle.
  task automatic cycle();
    logic ev;
    int   idx;
    @(negedge CLK);
    ev = (expq.size() > 0) && (expq[0].due == cyc);
    chk("wr_ready", wr_ready, !RST);
    chk("rd_req_ready", rd_req_ready, !RST && pend.size() == 0);
    chk("busy", busy, !RST && (pend.size() > 0 || expq.size() > 0));
    chk("rd_valid", rd_valid, ev);
    if (ev) begin
      last_data = expq[0].d;
      chk("rd_last", rd_last, expq[0].last);
      void'(expq.pop_front());
    end else begin
      chk("rd_last_idle", rd_last, 1'b0);
    end
    chk("rd_data", rd_data, last_data);
    if (RST) begin
      pend.delete();
      expq.delete();
      last_data = '0;
    end else begin
      if (rd_req_valid && pend.size() == 0)
        for (int k = 0; k <= int'(rd_len); k++)
          pend.push_back((int'(rd_row) * NC + int'(rd_col) + k) % NE);
      if (pend.size() > 0) begin
        idx = pend.pop_front();
        expq.push_back('{due: cyc + 2, d: mem_m[idx], last: (pend.size() == 0)});
      end
      if (wr_valid) mem_m[int'(wr_row) * NC + int'(wr_col)] = wr_data;
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic wr(input int r, input int c, input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_row = 4'(r); wr_col = 4'(c); wr_data = d;
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (pend.size() > 0 && n < 200) begin cycle(); n++; end
    n_total++;
    assert (pend.size() == 0) n_pass++;
    else $error("FAIL ready_timeout observed=%0d expected=0", pend.size());
  endtask

  task automatic burst(input int r, input int c, input int len);
    wait_ready();
    rd_req_valid = 1'b1; rd_row = 4'(r); rd_col = 4'(c); rd_len = LW'(len);
    cycle();
    rd_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((pend.size() > 0 || expq.size() > 0) && n < 300) begin cycle(); n++; end
    cycle();
    n_total++;
    assert (pend.size() == 0 && expq.size() == 0) n_pass++;
    else $error("FAIL drain_timeout observed=%0d expected=0", pend.size() + expq.size());
  endtask

  initial begin
    cyc = 0; n_pass = 0; n_total = 0; last_data = '0;
    RST = 1'b1; wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    rd_req_valid = 1'b0; rd_row = '0; rd_col = '0; rd_len = '0;
    repeat (2) @(posedge CLK);
    #1;
    cycle();
    RST = 1'b0;

    for (int i = 0; i < NE; i++) wr(i / NC, i % NC, $urandom);

    // Row 0 pattern and a 16-beat burst.
    for (int i = 0; i < 16; i++) wr(0, i, 32'hA5A50000 + i);
    burst(0, 0, 15);
    drain();

    // Last of bank 0 / first of bank 1 (indices 63, 64).
    wr(3, 15, 32'h0B0B_003F);
    wr(4, 0, 32'h0B1B_0040);
    burst(3, 15, 1);
    drain();

    // Wrap from (15,14) through (0,0).
    burst(15, 14, 3);
    drain();

    // Collision: element (1,3) is issued on the fourth cycle of the burst.
    rd_req_valid = 1'b1; rd_row = 4'd1; rd_col = 4'd0; rd_len = LW'(7);
    cycle();
    rd_req_valid = 1'b0;
    cycle(); cycle();
    wr_valid = 1'b1; wr_row = 4'd1; wr_col = 4'd3; wr_data = 32'hDEADBEEF;
    cycle();
    wr_valid = 1'b0;
    drain();
    burst(1, 3, 0);
    drain();

    // Reset in the middle of an 8-beat burst.
    burst(2, 0, 7);
    cycle(); cycle(); cycle();
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    repeat (6) cycle();
    burst(2, 0, 7);
    drain();

    // Back-to-back rd_len=0 then rd_len=2.
    burst(5, 5, 0);
    burst(6, 6, 2);
    drain();

    // Random writes and bursts, including overlaps with in-flight reads.
    for (int i = 0; i < 400; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_row = 4'($urandom); wr_col = 4'($urandom); wr_data = $urandom;
      rd_req_valid = (pend.size() == 0) && ($urandom_range(0, 2) == 0);
      rd_row = 4'($urandom); rd_col = 4'($urandom); rd_len = LW'($urandom_range(0, 15));
      cycle();
    end
    wr_valid = 1'b0; rd_req_valid = 1'b0;
    drain();

    // Full readback confirms every bank holds exactly what was written to it.
    for (int b = 0; b < NB; b++) burst(b * 4, 0, 63);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
